// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises the serial line, samples start/data/stop
// bits at mid-bit on oversample ticks, and reports each frame with a done or error pulse.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICKS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_s_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_END = TW'(SB_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic                   r_rxMeta;
    logic                   r_rxS;
    logic [TW-1:0]          r_tickCnt;
    logic [TW-1:0]          w_tickNext;
    logic [BW-1:0]          r_bitCnt;
    logic [BW-1:0]          w_bitNext;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   w_shregNext;
    logic [DATA_BITS-1:0]   r_data;
    logic [DATA_BITS-1:0]   w_dataNext;
    logic                   r_done;
    logic                   w_doneNext;
    logic                   r_err;
    logic                   w_errNext;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= i_rx;
            r_rxS    <= r_rxMeta;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_tickCnt <= '0;
            r_bitCnt  <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_tickCnt <= w_tickNext;
            r_bitCnt  <= w_bitNext;
            r_shreg   <= w_shregNext;
            r_data    <= w_dataNext;
            r_done    <= w_doneNext;
            r_err     <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_tickNext  = r_tickCnt;
        w_bitNext   = r_bitCnt;
        w_shregNext = r_shreg;
        w_dataNext  = r_data;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxS) begin
                    w_stateNext = S_START;
                    w_tickNext  = '0;
                end
            end
            // A start bit that is high again at its centre was a glitch and is dropped silently.
            S_START: begin
                if (i_s_tick) begin
                    if (r_tickCnt == MID_TICK) begin
                        if (!r_rxS) begin
                            w_stateNext = S_DATA;
                            w_tickNext  = '0;
                            w_bitNext   = '0;
                        end else begin
                            w_stateNext = S_IDLE;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TICK_ONE;
                    end
                end
            end
            S_DATA: begin
                if (i_s_tick) begin
                    if (r_tickCnt == BIT_END) begin
                        w_shregNext = {r_rxS, r_shreg[DATA_BITS-1:1]};
                        w_tickNext  = '0;
                        if (r_bitCnt == LAST_BIT) begin
                            w_stateNext = S_STOP;
                        end else begin
                            w_bitNext = r_bitCnt + BIT_ONE;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TICK_ONE;
                    end
                end
            end
            S_STOP: begin
                if (i_s_tick) begin
                    if (r_tickCnt == STOP_END) begin
                        w_tickNext = '0;
                        if (r_rxS) begin
                            w_dataNext  = r_shreg;
                            w_doneNext  = 1'b1;
                            w_stateNext = S_IDLE;
                        end else begin
                            w_errNext   = 1'b1;
                            w_stateNext = S_BREAK;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TICK_ONE;
                    end
                end
            end
            // A line held low after a bad stop bit must not be mistaken for a new start edge.
            S_BREAK: begin
                if (r_rxS) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_err;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are queued as expected events when sent,
// and a monitor pops and compares on every done/error pulse.
module tb_uart_rx_ctrl;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } evt_t;

    logic       clk;
    logic       reset;
    logic       sTick;
    logic       rx;
    logic [7:0] data;
    logic       rxDone;
    logic       frameErr;
    logic       busy;

    evt_t       expQ[$];
    logic [7:0] heldData;
    int         nTests;
    int         nFail;

    uart_rx_ctrl #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .SB_TICKS  (16)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_s_tick   (sTick),
        .i_rx       (rx),
        .o_data     (data),
        .o_rx_done  (rxDone),
        .o_frame_err(frameErr),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample tick: one clock high every four clocks, running continuously.
    initial begin
        sTick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sTick = 1'b1;
            @(negedge clk);
            sTick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Queues the expected event, then drives start, LSB-first data and stop bit.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        evt_t e;
        e.err = ~stopBit;
        e.data = stopBit ? value : heldData;
        if (stopBit) heldData = value;
        expQ.push_back(e);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(value[i]);
        sendBit(stopBit);
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, expQ.size(), 0);
    endtask

    // Monitor: every pulse must match the head of the queue, and the two pulses never coincide.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (rxDone || frameErr) begin
                checkOutput("pulse_exclusive", int'(rxDone && frameErr), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {rxDone, frameErr}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_kind", int'(frameErr), int'(e.err));
                    checkOutput("pulse_data", data, e.data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nTests   = 0;
        nFail    = 0;
        heldData = 8'h00;
        rx       = 1'b1;
        reset    = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", rxDone, 0);
        checkOutput("reset_err", frameErr, 0);
        reset = 1'b0;

        // Idle line with ticks running.
        repeat (1000) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_data", data, 8'h00);

        // Good frame.
        applyStimulus(8'hA5, 1'b1);
        checkDrained("frame_a5_drained");
        checkOutput("frame_a5_data", data, 8'hA5);
        repeat (100) @(negedge clk);

        // Short low glitch: 3 ticks.
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("glitch_busy", busy, 0);
        checkOutput("glitch_data", data, 8'hA5);
        checkDrained("glitch_no_pulse");

        // Framing error with line held low, then recovery.
        applyStimulus(8'h3C, 1'b0);
        checkDrained("ferr_drained");
        rx = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("break_busy", busy, 1);
        checkOutput("break_data", data, 8'hA5);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("break_released", busy, 0);
        repeat (60) @(negedge clk);
        applyStimulus(8'h5A, 1'b1);
        checkDrained("frame_5a_drained");
        checkOutput("frame_5a_data", data, 8'h5A);
        repeat (100) @(negedge clk);

        // Back-to-back frames, no idle gap.
        applyStimulus(8'h00, 1'b1);
        checkOutput("b2b_first_data", data, 8'h00);
        applyStimulus(8'hFF, 1'b1);
        checkDrained("b2b_drained");
        checkOutput("b2b_second_data", data, 8'hFF);
        repeat (100) @(negedge clk);

        // Reset in the middle of the data bits.
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS + 10) @(negedge clk);
        checkOutput("mid_frame_busy", busy, 1);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_data", data, 8'h00);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", rxDone, 0);
        checkOutput("midrst_err", frameErr, 0);
        reset    = 1'b0;
        heldData = 8'h00;
        repeat (200) @(negedge clk);
        checkOutput("post_rst_busy", busy, 0);
        applyStimulus(8'h81, 1'b1);
        checkDrained("frame_81_drained");
        checkOutput("frame_81_data", data, 8'h81);

        repeat (200) @(negedge clk);
        checkDrained("final_drained");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
